// File: rtl/rob_retire_if.sv
// Dispatch/complete/retire signal bundle for the reorder buffer.
// The core side drives through master; the ROB sits on slave.
interface rob_retire_if #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
);
  logic              alloc_valid_1, alloc_valid_2;
  logic [PREG_W-1:0] alloc_pd_1, alloc_pd_2;
  logic [PREG_W-1:0] alloc_old_pd_1, alloc_old_pd_2;
  logic              alloc_is_store_1, alloc_is_store_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1, alloc_idx_2;

  logic              cmp_valid_1, cmp_valid_2, cmp_valid_3;
  logic [IDX_W-1:0]  cmp_rob_1, cmp_rob_2, cmp_rob_3;
  logic [DATA_W-1:0] cmp_result_1, cmp_result_2, cmp_result_3;

  logic              retire_flag_1, retire_flag_2;
  logic [PREG_W-1:0] fp_ind_1, fp_ind_2;
  logic              ret_valid_1, ret_valid_2;
  logic [PREG_W-1:0] ret_pd_1, ret_pd_2;
  logic [DATA_W-1:0] ret_data_1, ret_data_2;
  logic              ret_is_store_1, ret_is_store_2;

  logic [IDX_W:0]    count;
  logic              empty, full;

  modport master (
    output alloc_valid_1, alloc_valid_2, alloc_pd_1, alloc_pd_2,
           alloc_old_pd_1, alloc_old_pd_2, alloc_is_store_1, alloc_is_store_2,
           cmp_valid_1, cmp_valid_2, cmp_valid_3, cmp_rob_1, cmp_rob_2, cmp_rob_3,
           cmp_result_1, cmp_result_2, cmp_result_3,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
           retire_flag_1, retire_flag_2, fp_ind_1, fp_ind_2,
           ret_valid_1, ret_valid_2, ret_pd_1, ret_pd_2, ret_data_1, ret_data_2,
           ret_is_store_1, ret_is_store_2, count, empty, full
  );

  modport slave (
    input  alloc_valid_1, alloc_valid_2, alloc_pd_1, alloc_pd_2,
           alloc_old_pd_1, alloc_old_pd_2, alloc_is_store_1, alloc_is_store_2,
           cmp_valid_1, cmp_valid_2, cmp_valid_3, cmp_rob_1, cmp_rob_2, cmp_rob_3,
           cmp_result_1, cmp_result_2, cmp_result_3,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
           retire_flag_1, retire_flag_2, fp_ind_1, fp_ind_2,
           ret_valid_1, ret_valid_2, ret_pd_1, ret_pd_2, ret_data_1, ret_data_2,
           ret_is_store_1, ret_is_store_2, count, empty, full
  );
endinterface

// File: rtl/rob_retire.sv
// Reorder buffer with dual in-order retire and free-pool release of old pregs.
// Entry payload arrays carry no reset; only the valid/complete flags and pointers do.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  rob_retire_if.slave bus
);
  localparam logic [IDX_W:0] CNT_FULL      = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_READY_MAX = (IDX_W+1)'(DEPTH - 2);

  logic [DEPTH-1:0]  ent_v, ent_comp, ent_store;
  logic [PREG_W-1:0] ent_pd     [DEPTH];
  logic [PREG_W-1:0] ent_old_pd [DEPTH];
  logic [DATA_W-1:0] ent_result [DEPTH];

  logic [IDX_W-1:0]  head, head_p1, tail, tail_p1;
  logic [IDX_W:0]    count;
  logic              alloc_ready, acc_1, acc_2;
  logic              sel_1, sel_2, rel_1, rel_2;
  logic              hit_1, hit_2, hit_3;

  assign head_p1 = head + IDX_W'(1);
  assign tail_p1 = tail + IDX_W'(1);

  // Space check uses registered count only, so a retire never opens room in its own cycle.
  assign alloc_ready = (count <= CNT_READY_MAX);
  assign acc_1       = alloc_ready & bus.alloc_valid_1;
  assign acc_2       = acc_1 & bus.alloc_valid_2;

  assign sel_1 = ent_v[head] & ent_comp[head];
  assign sel_2 = sel_1 & ent_v[head_p1] & ent_comp[head_p1];
  assign rel_1 = sel_1 & ~ent_store[head]    & (ent_old_pd[head] != '0);
  assign rel_2 = sel_2 & ~ent_store[head_p1] & (ent_old_pd[head_p1] != '0);

  // Lower-numbered port wins when several name the same entry.
  assign hit_1 = bus.cmp_valid_1 & ent_v[bus.cmp_rob_1] & ~ent_comp[bus.cmp_rob_1];
  assign hit_2 = bus.cmp_valid_2 & ent_v[bus.cmp_rob_2] & ~ent_comp[bus.cmp_rob_2]
               & ~(bus.cmp_valid_1 & (bus.cmp_rob_1 == bus.cmp_rob_2));
  assign hit_3 = bus.cmp_valid_3 & ent_v[bus.cmp_rob_3] & ~ent_comp[bus.cmp_rob_3]
               & ~(bus.cmp_valid_1 & (bus.cmp_rob_1 == bus.cmp_rob_3))
               & ~(bus.cmp_valid_2 & (bus.cmp_rob_2 == bus.cmp_rob_3));

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_idx_1 = tail;
  assign bus.alloc_idx_2 = tail_p1;
  assign bus.count       = count;
  assign bus.empty       = (count == '0);
  assign bus.full        = (count == CNT_FULL);

  // Retiring, completing and allocating entries never overlap: retirees are already
  // complete, and allocation only targets free slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v    <= '0;
      ent_comp <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (sel_1) begin
        ent_v[head]    <= 1'b0;
        ent_comp[head] <= 1'b0;
      end
      if (sel_2) begin
        ent_v[head_p1]    <= 1'b0;
        ent_comp[head_p1] <= 1'b0;
      end
      if (hit_1) ent_comp[bus.cmp_rob_1] <= 1'b1;
      if (hit_2) ent_comp[bus.cmp_rob_2] <= 1'b1;
      if (hit_3) ent_comp[bus.cmp_rob_3] <= 1'b1;
      if (acc_1) begin
        ent_v[tail]    <= 1'b1;
        ent_comp[tail] <= 1'b0;
      end
      if (acc_2) begin
        ent_v[tail_p1]    <= 1'b1;
        ent_comp[tail_p1] <= 1'b0;
      end
      head  <= head + IDX_W'(sel_1) + IDX_W'(sel_2);
      tail  <= tail + IDX_W'(acc_1) + IDX_W'(acc_2);
      count <= count + (IDX_W+1)'(acc_1) + (IDX_W+1)'(acc_2)
                     - (IDX_W+1)'(sel_1) - (IDX_W+1)'(sel_2);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_1) begin
      ent_store[tail]  <= bus.alloc_is_store_1;
      ent_pd[tail]     <= bus.alloc_pd_1;
      ent_old_pd[tail] <= bus.alloc_old_pd_1;
    end
    if (acc_2) begin
      ent_store[tail_p1]  <= bus.alloc_is_store_2;
      ent_pd[tail_p1]     <= bus.alloc_pd_2;
      ent_old_pd[tail_p1] <= bus.alloc_old_pd_2;
    end
    if (hit_1) ent_result[bus.cmp_rob_1] <= bus.cmp_result_1;
    if (hit_2) ent_result[bus.cmp_rob_2] <= bus.cmp_result_2;
    if (hit_3) ent_result[bus.cmp_rob_3] <= bus.cmp_result_3;
  end

  // Payload outputs are gated to zero when not retiring so unwritten slots never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ret_valid_1    <= 1'b0;
      bus.ret_valid_2    <= 1'b0;
      bus.ret_pd_1       <= '0;
      bus.ret_pd_2       <= '0;
      bus.ret_data_1     <= '0;
      bus.ret_data_2     <= '0;
      bus.ret_is_store_1 <= 1'b0;
      bus.ret_is_store_2 <= 1'b0;
      bus.retire_flag_1  <= 1'b0;
      bus.retire_flag_2  <= 1'b0;
      bus.fp_ind_1       <= '0;
      bus.fp_ind_2       <= '0;
    end else begin
      bus.ret_valid_1    <= sel_1;
      bus.ret_valid_2    <= sel_2;
      bus.ret_pd_1       <= sel_1 ? ent_pd[head]        : '0;
      bus.ret_pd_2       <= sel_2 ? ent_pd[head_p1]     : '0;
      bus.ret_data_1     <= sel_1 ? ent_result[head]    : '0;
      bus.ret_data_2     <= sel_2 ? ent_result[head_p1] : '0;
      bus.ret_is_store_1 <= sel_1 & ent_store[head];
      bus.ret_is_store_2 <= sel_2 & ent_store[head_p1];
      bus.retire_flag_1  <= rel_1;
      bus.retire_flag_2  <= rel_2;
      bus.fp_ind_1       <= rel_1 ? ent_old_pd[head]    : '0;
      bus.fp_ind_2       <= rel_2 ? ent_old_pd[head_p1] : '0;
    end
  end
endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed scenarios plus random traffic against a queue-based
// program-order model of the reorder buffer.
module tb_rob_retire;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_retire_if bus ();
  rob_retire dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          idx;
    logic [5:0]  pd;
    logic [5:0]  old;
    bit          st;
    bit          comp;
    logic [31:0] res;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  bit          e_rv[2], e_st[2], e_flag[2];
  logic [5:0]  e_pd[2], e_fp[2];
  logic [31:0] e_data[2];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.alloc_valid_1 = 0; bus.alloc_valid_2 = 0;
    bus.alloc_pd_1 = 0; bus.alloc_pd_2 = 0;
    bus.alloc_old_pd_1 = 0; bus.alloc_old_pd_2 = 0;
    bus.alloc_is_store_1 = 0; bus.alloc_is_store_2 = 0;
    bus.cmp_valid_1 = 0; bus.cmp_valid_2 = 0; bus.cmp_valid_3 = 0;
    bus.cmp_rob_1 = 0; bus.cmp_rob_2 = 0; bus.cmp_rob_3 = 0;
    bus.cmp_result_1 = 0; bus.cmp_result_2 = 0; bus.cmp_result_3 = 0;
  endtask

  task automatic set_alloc(input int k, input bit v, input logic [5:0] pd,
                           input logic [5:0] old, input bit st);
    if (k == 1) begin
      bus.alloc_valid_1 = v; bus.alloc_pd_1 = pd; bus.alloc_old_pd_1 = old; bus.alloc_is_store_1 = st;
    end else begin
      bus.alloc_valid_2 = v; bus.alloc_pd_2 = pd; bus.alloc_old_pd_2 = old; bus.alloc_is_store_2 = st;
    end
  endtask

  task automatic set_cmp(input int k, input bit v, input logic [3:0] rob, input logic [31:0] d);
    case (k)
      1: begin bus.cmp_valid_1 = v; bus.cmp_rob_1 = rob; bus.cmp_result_1 = d; end
      2: begin bus.cmp_valid_2 = v; bus.cmp_rob_2 = rob; bus.cmp_result_2 = d; end
      default: begin bus.cmp_valid_3 = v; bus.cmp_rob_3 = rob; bus.cmp_result_3 = d; end
    endcase
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    for (int s = 0; s < 2; s++) begin
      e_rv[s] = 0; e_st[s] = 0; e_flag[s] = 0; e_pd[s] = 0; e_fp[s] = 0; e_data[s] = 0;
    end
  endtask

  task automatic set_exp(input int s, input bit r, input ent_t e);
    e_rv[s]   = r;
    e_pd[s]   = r ? e.pd : 6'd0;
    e_data[s] = r ? e.res : 32'd0;
    e_st[s]   = r && e.st;
    e_flag[s] = r && !e.st && (e.old != 0);
    e_fp[s]   = e_flag[s] ? e.old : 6'd0;
  endtask

  // Advances the model across the coming edge using the inputs currently driven.
  task automatic model_step();
    ent_t        blank;
    bit          r1, r2, rdy, cv;
    int          n;
    logic [3:0]  rob;
    logic [31:0] res;
    blank = '{idx: 0, pd: 0, old: 0, st: 0, comp: 0, res: 0};
    n   = q.size();
    rdy = (16 - n) >= 2;
    r1  = (n > 0) && q[0].comp;
    r2  = r1 && (n > 1) && q[1].comp;
    set_exp(0, r1, r1 ? q[0] : blank);
    set_exp(1, r2, r2 ? q[1] : blank);
    for (int k = 1; k <= 3; k++) begin
      case (k)
        1: begin cv = bus.cmp_valid_1; rob = bus.cmp_rob_1; res = bus.cmp_result_1; end
        2: begin cv = bus.cmp_valid_2; rob = bus.cmp_rob_2; res = bus.cmp_result_2; end
        default: begin cv = bus.cmp_valid_3; rob = bus.cmp_rob_3; res = bus.cmp_result_3; end
      endcase
      if (cv) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].idx == int'(rob) && !q[i].comp) begin
            q[i].comp = 1;
            q[i].res  = res;
          end
        end
      end
    end
    if (r1) void'(q.pop_front());
    if (r2) void'(q.pop_front());
    if (rdy && bus.alloc_valid_1) begin
      q.push_back('{idx: m_tail, pd: bus.alloc_pd_1, old: bus.alloc_old_pd_1,
                    st: bus.alloc_is_store_1, comp: 0, res: 0});
      m_tail = (m_tail + 1) % 16;
      if (bus.alloc_valid_2) begin
        q.push_back('{idx: m_tail, pd: bus.alloc_pd_2, old: bus.alloc_old_pd_2,
                      st: bus.alloc_is_store_2, comp: 0, res: 0});
        m_tail = (m_tail + 1) % 16;
      end
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check("ret_valid_1", bus.ret_valid_1, e_rv[0]);
    check("ret_valid_2", bus.ret_valid_2, e_rv[1]);
    check("ret_pd_1", bus.ret_pd_1, e_pd[0]);
    check("ret_pd_2", bus.ret_pd_2, e_pd[1]);
    check("ret_data_1", bus.ret_data_1, e_data[0]);
    check("ret_data_2", bus.ret_data_2, e_data[1]);
    check("ret_is_store_1", bus.ret_is_store_1, e_st[0]);
    check("ret_is_store_2", bus.ret_is_store_2, e_st[1]);
    check("retire_flag_1", bus.retire_flag_1, e_flag[0]);
    check("retire_flag_2", bus.retire_flag_2, e_flag[1]);
    check("fp_ind_1", bus.fp_ind_1, e_fp[0]);
    check("fp_ind_2", bus.fp_ind_2, e_fp[1]);
    check("count", bus.count, n);
    check("empty", bus.empty, n == 0);
    check("full", bus.full, n == 16);
    check("alloc_ready", bus.alloc_ready, (16 - n) >= 2);
    check("alloc_idx_1", bus.alloc_idx_1, m_tail);
    check("alloc_idx_2", bus.alloc_idx_2, (m_tail + 1) % 16);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // basic retire
    set_alloc(1, 1, 6'd33, 6'd5, 0);
    set_alloc(2, 1, 6'd34, 6'd6, 0);
    cycle();
    clear_inputs();
    set_cmp(1, 1, 4'd0, 32'h11);
    set_cmp(3, 1, 4'd1, 32'h22);
    cycle();
    clear_inputs();
    cycle();
    check("basic_valid_1", bus.ret_valid_1, 1);
    check("basic_valid_2", bus.ret_valid_2, 1);
    check("basic_data_1", bus.ret_data_1, 32'h11);
    check("basic_data_2", bus.ret_data_2, 32'h22);
    check("basic_fp_1", bus.fp_ind_1, 5);
    check("basic_fp_2", bus.fp_ind_2, 6);
    check("basic_count", bus.count, 0);
    cycle();
    check("basic_one_shot", bus.ret_valid_1, 0);

    // out-of-order completion
    do_reset();
    set_alloc(1, 1, 6'd10, 6'd1, 0); set_alloc(2, 1, 6'd11, 6'd2, 0);
    cycle();
    set_alloc(1, 1, 6'd12, 6'd3, 0); set_alloc(2, 1, 6'd13, 6'd4, 0);
    cycle();
    for (int i = 3; i >= 0; i--) begin
      clear_inputs();
      set_cmp(1, 1, 4'(i), 32'h100 + 32'(i));
      cycle();
      check("ooo_hold", bus.ret_valid_1, 0);
    end
    clear_inputs();
    cycle();
    check("ooo_first_pd_1", bus.ret_pd_1, 10);
    check("ooo_first_pd_2", bus.ret_pd_2, 11);
    cycle();
    check("ooo_second_pd_1", bus.ret_pd_1, 12);
    check("ooo_second_pd_2", bus.ret_pd_2, 13);

    // full and wrap
    do_reset();
    for (int p = 0; p < 7; p++) begin
      set_alloc(1, 1, 6'(2 * p + 1), 6'd9, 0);
      set_alloc(2, 1, 6'(2 * p + 2), 6'd9, 0);
      cycle();
    end
    check("fill_ready_14", bus.alloc_ready, 1);
    cycle();
    check("fill_full", bus.full, 1);
    check("fill_ready_16", bus.alloc_ready, 0);
    cycle();
    check("fill_dropped", bus.count, 16);
    clear_inputs();
    set_cmp(1, 1, 4'd0, 32'hAAAA);
    cycle();
    clear_inputs();
    cycle();
    check("count_15", bus.count, 15);
    check("ready_at_15", bus.alloc_ready, 0);
    set_cmp(1, 1, 4'd1, 32'hBBBB);
    cycle();
    clear_inputs();
    cycle();
    check("ready_at_14", bus.alloc_ready, 1);
    check("wrap_idx_1", bus.alloc_idx_1, 0);
    check("wrap_idx_2", bus.alloc_idx_2, 1);

    // stores and x0
    do_reset();
    set_alloc(1, 1, 6'd20, 6'd7, 1);
    set_alloc(2, 1, 6'd21, 6'd0, 0);
    cycle();
    clear_inputs();
    set_cmp(1, 1, 4'd0, 32'h5);
    set_cmp(2, 1, 4'd1, 32'h6);
    cycle();
    clear_inputs();
    cycle();
    check("store_valid", bus.ret_valid_1, 1);
    check("store_is_store", bus.ret_is_store_1, 1);
    check("store_flag", bus.retire_flag_1, 0);
    check("x0_valid", bus.ret_valid_2, 1);
    check("x0_flag", bus.retire_flag_2, 0);

    // bad completions
    do_reset();
    set_cmp(1, 1, 4'd5, 32'h55);
    cycle();
    clear_inputs();
    for (int p = 0; p < 3; p++) begin
      set_alloc(1, 1, 6'(40 + 2 * p), 6'd8, 0);
      set_alloc(2, 1, 6'(41 + 2 * p), 6'd8, 0);
      cycle();
    end
    clear_inputs();
    set_cmp(1, 1, 4'd0, 32'hA);
    set_cmp(2, 1, 4'd0, 32'hB);
    set_cmp(3, 1, 4'd1, 32'hC);
    cycle();
    clear_inputs();
    set_cmp(1, 1, 4'd2, 32'h2);
    set_cmp(2, 1, 4'd3, 32'h3);
    set_cmp(3, 1, 4'd4, 32'h4);
    cycle();
    check("dup_port_win", bus.ret_data_1, 32'hA);
    clear_inputs();
    for (int i = 0; i < 4; i++) cycle();
    check("unalloc_cmp_ignored", bus.count, 1);

    // reset mid-operation
    do_reset();
    for (int p = 0; p < 3; p++) begin
      set_alloc(1, 1, 6'(50 + 2 * p), 6'(1 + 2 * p), 0);
      set_alloc(2, 1, 6'(51 + 2 * p), 6'(2 + 2 * p), 0);
      cycle();
    end
    clear_inputs();
    set_cmp(1, 1, 4'd0, 32'h70);
    set_cmp(2, 1, 4'd1, 32'h71);
    set_cmp(3, 1, 4'd2, 32'h72);
    cycle();
    clear_inputs();
    cycle();
    check("pre_rst_flag", bus.retire_flag_1, 1);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    check("rst_flag_1", bus.retire_flag_1, 0);
    check("rst_empty", bus.empty, 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("post_rst_flag_1", bus.retire_flag_1, 0);
      check("post_rst_flag_2", bus.retire_flag_2, 0);
    end

    // random traffic
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      clear_inputs();
      if ($urandom_range(0, 3) != 0)
        set_alloc(1, 1, 6'($urandom_range(1, 63)),
                  ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                  $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) != 0)
        set_alloc(2, 1, 6'($urandom_range(1, 63)),
                  ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                  $urandom_range(0, 5) == 0);
      for (int k = 1; k <= 3; k++) begin
        if ($urandom_range(0, 9) < 6) begin
          logic [3:0] rob;
          if (q.size() > 0 && $urandom_range(0, 3) != 0)
            rob = 4'(q[$urandom_range(0, q.size() - 1)].idx);
          else
            rob = 4'($urandom_range(0, 15));
          set_cmp(k, 1, rob, $urandom);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
